// File: rtl/dsp_simd_lane_sched.sv
// rtl/dsp_simd_lane_sched.sv - round-robin packer of up to three requests per cycle onto a shared 3-lane SIMD OR datapath
// Optional grant/idle-lane counters are built when DSP_SIMD_LANE_SCHED_STATS_EN is defined.
module dsp_simd_lane_sched #(
  parameter int width   = 12,
  parameter int num_req = 4,
  parameter int ptr_w   = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [num_req-1:0]       req_valid,
  output logic [num_req-1:0]       req_ready,
  input  logic [num_req*width-1:0] req_a,
  input  logic [num_req*width-1:0] req_b,
  output logic [num_req-1:0]       rsp_valid,
  output logic [num_req*width-1:0] rsp_data,
  output logic [width-1:0]         lane_a0,
  output logic [width-1:0]         lane_b0,
  output logic [width-1:0]         lane_a1,
  output logic [width-1:0]         lane_b1,
  output logic [width-1:0]         lane_a2,
  output logic [width-1:0]         lane_b2,
  input  logic [width-1:0]         lane_y0,
  input  logic [width-1:0]         lane_y1,
  input  logic [width-1:0]         lane_y2
`ifdef DSP_SIMD_LANE_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_idle_lanes
`endif
);

  logic [ptr_w-1:0]         rr_ptr_q, rr_ptr_d;
  logic [num_req-1:0]       grant;
  logic [1:0]               lane_cnt;
  logic [ptr_w-1:0]         last_id;

  logic [2:0]               sel_vld;
  logic [ptr_w-1:0]         sel_id [3];
  logic [width-1:0]         sel_a  [3];
  logic [width-1:0]         sel_b  [3];

  logic [2:0]               lane_vld_q;
  logic [ptr_w-1:0]         lane_id_q [3];
  logic [width-1:0]         lane_a_q  [3];
  logic [width-1:0]         lane_b_q  [3];
  logic [width-1:0]         lane_y    [3];

  logic [num_req-1:0]       rsp_valid_q, rsp_valid_d;
  logic [num_req*width-1:0] rsp_data_q, rsp_data_d;

  // Two passes walk requesters rr_ptr..num_req-1 then 0..rr_ptr-1, giving a wrapped scan
  always_comb begin
    grant    = '0;
    lane_cnt = 2'd0;
    last_id  = rr_ptr_q;
    sel_vld  = '0;
    for (int l = 0; l < 3; l++) begin
      sel_id[l] = '0;
      sel_a[l]  = '0;
      sel_b[l]  = '0;
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < num_req; i++) begin
        if (((p == 0) ? (i >= int'(rr_ptr_q)) : (i < int'(rr_ptr_q))) &&
            !reset && req_valid[i] && (lane_cnt != 2'd3)) begin
          grant[i]          = 1'b1;
          sel_vld[lane_cnt] = 1'b1;
          sel_id[lane_cnt]  = ptr_w'(i);
          sel_a[lane_cnt]   = req_a[i*width +: width];
          sel_b[lane_cnt]   = req_b[i*width +: width];
          last_id           = ptr_w'(i);
          lane_cnt          = lane_cnt + 2'd1;
        end
      end
    end
  end

  always_comb begin
    if (int'(last_id) >= num_req - 1) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = last_id + ptr_w'(1);
    end
  end

  assign req_ready = grant;

  assign lane_y[0] = lane_y0;
  assign lane_y[1] = lane_y1;
  assign lane_y[2] = lane_y2;

  // Results come back combinationally from the issue-register operands
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int l = 0; l < 3; l++) begin
      if (lane_vld_q[l]) begin
        for (int i = 0; i < num_req; i++) begin
          if (lane_id_q[l] == ptr_w'(i)) begin
            rsp_valid_d[i]               = 1'b1;
            rsp_data_d[i*width +: width] = lane_y[l];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      lane_vld_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int l = 0; l < 3; l++) begin
        lane_id_q[l] <= '0;
        lane_a_q[l]  <= '0;
        lane_b_q[l]  <= '0;
      end
    end else begin
      if (lane_cnt != 2'd0) begin
        rr_ptr_q <= rr_ptr_d;
      end
      lane_vld_q  <= sel_vld;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int l = 0; l < 3; l++) begin
        lane_id_q[l] <= sel_id[l];
        lane_a_q[l]  <= sel_a[l];
        lane_b_q[l]  <= sel_b[l];
      end
    end
  end

  assign lane_a0   = lane_a_q[0];
  assign lane_b0   = lane_b_q[0];
  assign lane_a1   = lane_a_q[1];
  assign lane_b1   = lane_b_q[1];
  assign lane_a2   = lane_a_q[2];
  assign lane_b2   = lane_b_q[2];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef DSP_SIMD_LANE_SCHED_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_idle_q, stat_idle_d;

  always_comb begin
    stat_ops_d  = stat_ops_q + 32'(lane_cnt);
    stat_idle_d = stat_idle_q;
    if ((lane_cnt != 2'd0) && (lane_cnt != 2'd3)) begin
      stat_idle_d = stat_idle_q + 32'(2'd3 - lane_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops_q  <= '0;
      stat_idle_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_idle_q <= stat_idle_d;
    end
  end

  assign stat_ops        = stat_ops_q;
  assign stat_idle_lanes = stat_idle_q;
`endif

endmodule

// File: tb/tb_dsp_simd_lane_sched.sv
// tb/tb_dsp_simd_lane_sched.sv - directed self-checking bench for dsp_simd_lane_sched
module tb_dsp_simd_lane_sched;
  localparam int W = 12;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_data;
  logic [W-1:0]   lane_a0, lane_b0, lane_a1, lane_b1, lane_a2, lane_b2;
  logic [W-1:0]   lane_y0, lane_y1, lane_y2;
`ifdef DSP_SIMD_LANE_SCHED_STATS_EN
  logic [31:0]    stat_ops, stat_idle_lanes;
`endif

  int checks = 0;
  int errors = 0;

  dsp_simd_lane_sched #(.width(W), .num_req(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lane_a0(lane_a0), .lane_b0(lane_b0),
    .lane_a1(lane_a1), .lane_b1(lane_b1),
    .lane_a2(lane_a2), .lane_b2(lane_b2),
    .lane_y0(lane_y0), .lane_y1(lane_y1), .lane_y2(lane_y2)
`ifdef DSP_SIMD_LANE_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_idle_lanes(stat_idle_lanes)
`endif
  );

  always #5 clock = ~clock;

  // Stand-in for the DSP wrapper: lane-wise OR, no register
  assign lane_y0 = lane_a0 | lane_b0;
  assign lane_y1 = lane_a1 | lane_b1;
  assign lane_y2 = lane_a2 | lane_b2;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  int cnt [N];
  int last [N];
  int max_gap;

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = {12'h808, 12'h400, 12'h220, 12'h100};
    req_b     = {12'h070, 12'h0C3, 12'h002, 12'h001};
    #1;
    chk("ready_in_reset", 48'(req_ready), 48'h0);
    tick();
    tick();
    chk("ready_in_reset2", 48'(req_ready), 48'h0);
    chk("rst_rsp_valid", 48'(rsp_valid), 48'h0);
    chk("rst_rsp_data", 48'(rsp_data), 48'h0);
    chk("rst_lanes", {lane_a0, lane_b0, lane_a2, lane_b2}, 48'h0);
    chk("rst_ptr", 48'(dut.rr_ptr_q), 48'h0);

    // Single request from requester 0
    reset     = 1'b0;
    req_valid = 4'b0001;
    req_a     = {12'h808, 12'h400, 12'h220, 12'h0F0};
    req_b     = {12'h070, 12'h0C3, 12'h002, 12'h00F};
    #1;
    chk("single_ready", 48'(req_ready), 48'h1);
    tick();
    req_valid = 4'b0000;
    chk("single_lane0", {24'h0, lane_a0, lane_b0}, {24'h0, 12'h0F0, 12'h00F});
    chk("single_lane1_zero", {24'h0, lane_a1, lane_b1}, 48'h0);
    chk("single_ptr", 48'(dut.rr_ptr_q), 48'h1);
    chk("single_no_rsp_yet", 48'(rsp_valid), 48'h0);
    tick();
    chk("single_rsp_valid", 48'(rsp_valid), 48'h1);
    chk("single_rsp_data", 48'(rsp_data), 48'h0FF);
    tick();
    chk("single_rsp_pulse", 48'(rsp_valid), 48'h0);
    chk("single_rsp_hold", 48'(rsp_data), 48'h0FF);

    // Reset pulse returns the pointer to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // All four valid for two cycles
    req_a     = {12'h808, 12'h400, 12'h220, 12'h100};
    req_b     = {12'h070, 12'h0C3, 12'h002, 12'h001};
    req_valid = 4'b1111;
    #1;
    chk("all_ready_c0", 48'(req_ready), 48'h7);
    tick();
    chk("all_ready_c1", 48'(req_ready), 48'hB);
    chk("all_ptr_c0", 48'(dut.rr_ptr_q), 48'h3);
    chk("all_lanes_a_c0", {12'h0, lane_a0, lane_a1, lane_a2}, {12'h0, 12'h100, 12'h220, 12'h400});
    chk("all_lanes_b_c0", {12'h0, lane_b0, lane_b1, lane_b2}, {12'h0, 12'h001, 12'h002, 12'h0C3});
    tick();
    req_valid = 4'b0000;
    chk("all_ptr_c1", 48'(dut.rr_ptr_q), 48'h2);
    chk("all_lanes_a_c1", {12'h0, lane_a0, lane_a1, lane_a2}, {12'h0, 12'h808, 12'h100, 12'h220});
    chk("all_rsp_valid_c0", 48'(rsp_valid), 48'h7);
    chk("all_rsp_data_c0", rsp_data, 48'h000_4C3_222_101);
    tick();
    chk("all_rsp_valid_c1", 48'(rsp_valid), 48'hB);
    chk("all_rsp_data_c1", rsp_data, 48'h878_4C3_222_101);

    // Move pointer to 3, then wrap and skip with 1010
    req_valid = 4'b0100;
    #1;
    chk("skip_pre_ready", 48'(req_ready), 48'h4);
    tick();
    chk("skip_ptr3", 48'(dut.rr_ptr_q), 48'h3);
    req_valid = 4'b1010;
    #1;
    chk("skip_ready", 48'(req_ready), 48'hA);
    tick();
    req_valid = 4'b0000;
    chk("skip_lanes_a", {12'h0, lane_a0, lane_a1, lane_a2}, {12'h0, 12'h808, 12'h220, 12'h000});
    chk("skip_lanes_b", {12'h0, lane_b0, lane_b1, lane_b2}, {12'h0, 12'h070, 12'h002, 12'h000});
    chk("skip_ptr", 48'(dut.rr_ptr_q), 48'h2);
    tick();
    chk("skip_rsp_valid", 48'(rsp_valid), 48'hA);
    tick();

    // Fairness: all four held valid for 12 cycles
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      last[i] = -1;
    end
    max_gap   = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          cnt[i]++;
          if (c - last[i] > max_gap) max_gap = c - last[i];
          last[i] = c;
        end
      end
      tick();
    end
    req_valid = 4'b0000;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fair_count%0d", i), 48'(cnt[i]), 48'd9);
    end
    chk("fair_gap_le2", 48'(max_gap <= 2), 48'h1);
    tick();
    tick();

    // Reset while three ops are in the issue stage
    req_valid = 4'b0111;
    #1;
    chk("midrst_ready", 48'(req_ready), 48'h7);
    tick();
    reset     = 1'b1;
    req_valid = 4'b0000;
    tick();
    chk("midrst_rsp_valid", 48'(rsp_valid), 48'h0);
    chk("midrst_rsp_data", rsp_data, 48'h0);
    chk("midrst_ptr", 48'(dut.rr_ptr_q), 48'h0);
    chk("midrst_lanes", {lane_a0, lane_a1, lane_a2, 12'h0}, 48'h0);
    reset = 1'b0;
    tick();
    chk("midrst_rsp_after", 48'(rsp_valid), 48'h0);

`ifdef DSP_SIMD_LANE_SCHED_STATS_EN
    chk("stat_ops_zero", 48'(stat_ops), 48'd0);
    req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) tick();
    req_valid = 4'b1111;
    tick();
    req_valid = 4'b0000;
    chk("stat_ops", 48'(stat_ops), 48'd7);
    chk("stat_idle_lanes", 48'(stat_idle_lanes), 48'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
